// File: rtl/t03_fetch_sequencer_pkg.sv
// Shared types and constants for the team_03 fetch sequencer.
package t03_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, FAULT} fetch_state_t;

  typedef enum logic [1:0] {
    F_NONE     = 2'b00,
    F_MISALIGN = 2'b01,
    F_TIMEOUT  = 2'b10
  } fault_code_t;

  localparam logic [1:0] CTRL_SEQ  = 2'b00;
  localparam logic [1:0] CTRL_JALR = 2'b01;
  localparam logic [1:0] CTRL_BR   = 2'b10;

  localparam int unsigned INSTR_BYTES = 4;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/t03_fetch_sequencer_if.sv
// Instruction-memory request/ack bundle between the fetch sequencer and imem.
interface t03_fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;

  modport master (output imem_req, output imem_addr, input imem_ack, input imem_data);
  modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_data);
endinterface

// File: rtl/t03_next_pc.sv
// Next-PC selection from the branchControl redirect code, with alignment check.
module t03_next_pc
  import t03_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_data,
  input  logic [1:0]  control,
  output logic [31:0] target,
  output logic        misaligned
);

  // JALR bit wins over the branch bit when both are set.
  always_comb begin
    target = pc + 32'(INSTR_BYTES);
    if ((control & CTRL_JALR) != 2'b00)
      target = (rs1_data + imm) & ~32'h1;
    else if ((control & CTRL_BR) != 2'b00)
      target = pc + imm;
    misaligned = is_misaligned(target);
  end

endmodule

// File: rtl/t03_fetch_sequencer.sv
// Program counter owner: fetches from imem, waits for execute, selects next PC,
// and parks in a sticky fault state on misaligned targets or fetch timeouts.
module t03_fetch_sequencer
  import t03_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [7:0]  IMEM_TIMEOUT = 8'd255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  t03_fetch_sequencer_if.master         imem,
  output logic [31:0]                   instr,
  output logic                          instr_valid,
  input  logic                          exec_done,
  input  logic [1:0]                    control,
  input  logic [31:0]                   imm,
  input  logic [31:0]                   rs1_data,
  output logic [31:0]                   pc,
  output logic [31:0]                   link_addr,
  output logic                          fault,
  output logic [1:0]                    fault_code,
  output logic [31:0]                   fault_pc
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_instr;
  logic [7:0]   r_cnt;
  fault_code_t  r_fault_code;
  logic [31:0]  r_fault_pc;

  logic [31:0]  w_target;
  logic         w_misaligned;
  logic         w_timeout;

  t03_next_pc u_next_pc (
    .pc         (r_pc),
    .imm        (imm),
    .rs1_data   (rs1_data),
    .control    (control),
    .target     (w_target),
    .misaligned (w_misaligned)
  );

  // Widened compare so the counter never wraps before the limit is seen.
  assign w_timeout = (9'(r_cnt) + 9'd1) >= 9'(IMEM_TIMEOUT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_pc         <= RESET_PC;
      r_instr      <= '0;
      r_cnt        <= '0;
      r_fault_code <= F_NONE;
      r_fault_pc   <= '0;
    end else begin
      case (r_state)
        IDLE: if (en) r_state <= FETCH;
        FETCH: begin
          if (imem.imem_ack) begin
            r_instr <= imem.imem_data;
            r_cnt   <= '0;
            r_state <= EXEC;
          end else if (w_timeout) begin
            r_fault_code <= F_TIMEOUT;
            r_fault_pc   <= r_pc;
            r_state      <= FAULT;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        EXEC: begin
          if (exec_done) begin
            if (w_misaligned) begin
              r_fault_code <= F_MISALIGN;
              r_fault_pc   <= r_pc;
              r_state      <= FAULT;
            end else begin
              r_pc    <= w_target;
              r_state <= en ? FETCH : IDLE;
            end
          end
        end
        FAULT: r_state <= FAULT;
      endcase
    end
  end

  assign imem.imem_req  = (r_state == FETCH);
  assign imem.imem_addr = r_pc;
  assign instr          = r_instr;
  assign instr_valid    = (r_state == EXEC);
  assign pc             = r_pc;
  assign link_addr      = r_pc + 32'(INSTR_BYTES);
  assign fault          = (r_state == FAULT);
  assign fault_code     = r_fault_code;
  assign fault_pc       = r_fault_pc;

endmodule

// File: tb/tb_t03_fetch_sequencer.sv
// Directed bench for t03_fetch_sequencer with a 4-cycle fetch timeout.
module tb_t03_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] instr;
  logic        instr_valid;
  logic        exec_done;
  logic [1:0]  control;
  logic [31:0] imm;
  logic [31:0] rs1_data;
  logic [31:0] pc;
  logic [31:0] link_addr;
  logic        fault;
  logic [1:0]  fault_code;
  logic [31:0] fault_pc;

  int unsigned errors = 0;
  int unsigned checks = 0;

  t03_fetch_sequencer_if imem_if ();

  t03_fetch_sequencer #(
    .RESET_PC     (32'h0000_0000),
    .IMEM_TIMEOUT (8'd4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .imem        (imem_if),
    .instr       (instr),
    .instr_valid (instr_valid),
    .exec_done   (exec_done),
    .control     (control),
    .imm         (imm),
    .rs1_data    (rs1_data),
    .pc          (pc),
    .link_addr   (link_addr),
    .fault       (fault),
    .fault_code  (fault_code),
    .fault_pc    (fault_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fetch_ack(input logic [31:0] d);
    imem_if.imem_ack  = 1'b1;
    imem_if.imem_data = d;
    tick();
    imem_if.imem_ack  = 1'b0;
  endtask

  task automatic exec_instr(input logic [1:0] c, input logic [31:0] i, input logic [31:0] r);
    control   = c;
    imm       = i;
    rs1_data  = r;
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    control   = 2'b00;
    imm       = '0;
    rs1_data  = '0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; exec_done = 1'b0; control = 2'b00; imm = '0; rs1_data = '0;
    imem_if.imem_ack = 1'b0; imem_if.imem_data = '0;
    tick(); tick();

    chk("rst_req",        32'(imem_if.imem_req), 32'd0);
    chk("rst_ivalid",     32'(instr_valid), 32'd0);
    chk("rst_pc",         pc, 32'h0);
    chk("rst_instr",      instr, 32'h0);
    chk("rst_fault",      32'(fault), 32'd0);
    chk("rst_fault_code", 32'(fault_code), 32'd0);
    chk("rst_fault_pc",   fault_pc, 32'h0);

    // Sequential flow with 0-wait memory
    rst = 1'b0; en = 1'b1;
    tick();
    chk("f1_req",  32'(imem_if.imem_req), 32'd1);
    chk("f1_addr", imem_if.imem_addr, 32'h0);
    fetch_ack(32'h0000_0013);
    chk("e1_ivalid", 32'(instr_valid), 32'd1);
    chk("e1_instr",  instr, 32'h0000_0013);
    chk("e1_req",    32'(imem_if.imem_req), 32'd0);
    exec_instr(2'b00, 32'h0, 32'h0);
    chk("seq_pc",     pc, 32'h4);
    chk("seq_req",    32'(imem_if.imem_req), 32'd1);
    chk("seq_addr",   imem_if.imem_addr, 32'h4);
    chk("seq_ivalid", 32'(instr_valid), 32'd0);

    // Forward branch to 0x10, then backward branch to 0x8
    fetch_ack(32'h00c0_0063);
    exec_instr(2'b10, 32'h0000_000C, 32'h0);
    chk("br_fwd_pc", pc, 32'h10);
    fetch_ack(32'hfe00_0ce3);
    chk("br_link", link_addr, 32'h14);
    exec_instr(2'b10, 32'hFFFF_FFF8, 32'h0);
    chk("br_back_pc",   pc, 32'h8);
    chk("br_back_addr", imem_if.imem_addr, 32'h8);
    chk("br_back_req",  32'(imem_if.imem_req), 32'd1);

    // Reach 0x20, then JALR with both control bits set
    fetch_ack(32'h0180_006f);
    exec_instr(2'b10, 32'h0000_0018, 32'h0);
    chk("to20_pc", pc, 32'h20);
    fetch_ack(32'h0040_80e7);
    chk("jalr_link", link_addr, 32'h24);
    control = 2'b11; imm = 32'h1; rs1_data = 32'h555;
    tick();
    chk("exec_hold_pc",     pc, 32'h20);
    chk("exec_hold_ivalid", 32'(instr_valid), 32'd1);
    exec_instr(2'b11, 32'h0000_0004, 32'h0000_0101);
    chk("jalr_pc",  pc, 32'h104);
    chk("jalr_req", 32'(imem_if.imem_req), 32'd1);

    // en low on exec_done parks in IDLE with the updated pc
    fetch_ack(32'h0000_0013);
    en = 1'b0;
    exec_instr(2'b00, 32'h0, 32'h0);
    chk("idle_pc",     pc, 32'h108);
    chk("idle_req",    32'(imem_if.imem_req), 32'd0);
    chk("idle_ivalid", 32'(instr_valid), 32'd0);
    tick();
    chk("idle_stay_req", 32'(imem_if.imem_req), 32'd0);
    en = 1'b1;
    tick();
    chk("resume_addr", imem_if.imem_addr, 32'h108);

    // Ack on the 4th FETCH cycle beats the timeout
    tick(); tick(); tick();
    chk("late_req",   32'(imem_if.imem_req), 32'd1);
    chk("late_fault", 32'(fault), 32'd0);
    fetch_ack(32'hDEAD_BEEF);
    chk("late_ack_fault",  32'(fault), 32'd0);
    chk("late_ack_instr",  instr, 32'hDEAD_BEEF);
    chk("late_ack_ivalid", 32'(instr_valid), 32'd1);
    exec_instr(2'b00, 32'h0, 32'h0);
    chk("to10c_pc", pc, 32'h10C);

    // Reach 0x40, then a misaligned branch target
    fetch_ack(32'h0000_0013);
    exec_instr(2'b10, 32'hFFFF_FF34, 32'h0);
    chk("to40_pc", pc, 32'h40);
    fetch_ack(32'h0000_0013);
    exec_instr(2'b10, 32'h0000_0006, 32'h0);
    chk("mis_fault",      32'(fault), 32'd1);
    chk("mis_fault_code", 32'(fault_code), 32'd1);
    chk("mis_fault_pc",   fault_pc, 32'h40);
    chk("mis_pc",         pc, 32'h40);
    chk("mis_req",        32'(imem_if.imem_req), 32'd0);
    chk("mis_ivalid",     32'(instr_valid), 32'd0);
    imem_if.imem_ack = 1'b1;
    exec_instr(2'b00, 32'h0, 32'h0);
    tick();
    imem_if.imem_ack = 1'b0;
    chk("sticky_fault", 32'(fault), 32'd1);
    chk("sticky_pc",    pc, 32'h40);
    chk("sticky_req",   32'(imem_if.imem_req), 32'd0);

    // Reset clears the fault; then a fetch that never gets an ack
    rst = 1'b1;
    #1;
    chk("clr_fault", 32'(fault), 32'd0);
    chk("clr_pc",    pc, 32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("to_req", 32'(imem_if.imem_req), 32'd1);
    tick(); tick(); tick();
    chk("to_pre_fault", 32'(fault), 32'd0);
    chk("to_pre_req",   32'(imem_if.imem_req), 32'd1);
    tick();
    chk("to_fault",      32'(fault), 32'd1);
    chk("to_fault_code", 32'(fault_code), 32'd2);
    chk("to_fault_pc",   fault_pc, 32'h0);
    chk("to_req_low",    32'(imem_if.imem_req), 32'd0);

    // Asynchronous reset in the middle of a fetch
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    fetch_ack(32'h0000_0013);
    exec_instr(2'b00, 32'h0, 32'h0);
    chk("pre_rst_pc",  pc, 32'h4);
    chk("pre_rst_req", 32'(imem_if.imem_req), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_req", 32'(imem_if.imem_req), 32'd0);
    chk("async_rst_pc",  pc, 32'h0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
